// File: rtl/neural_burning_pkg.sv
// Shared types and constants for the code fetch path: sequencer state encoding,
// the halt opcode and the default code/index widths.
package neural_burning_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } fetch_state_t;

   localparam logic [3:0] HALT_OP             = 4'hF;
   localparam int         DEFAULT_CODE_WIDTH  = 12;
   localparam int         DEFAULT_INDEX_WIDTH = 32;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of {code, index} words between the storage read port and the
// fetch-to-decode handshake. Head outputs read as zero while the FIFO is empty.
module fetch_skid_buffer #(
   parameter int CODE_WIDTH  = 12,
   parameter int INDEX_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [CODE_WIDTH-1:0]  push_code,
   input  logic [INDEX_WIDTH-1:0] push_index,
   input  logic                   pop,
   output logic [CODE_WIDTH-1:0]  head_code,
   output logic [INDEX_WIDTH-1:0] head_index,
   output logic [1:0]             count
);

   logic [CODE_WIDTH-1:0]  entry_code  [2];
   logic [INDEX_WIDTH-1:0] entry_index [2];
   logic                   wr_ptr_reg;
   logic                   rd_ptr_reg;
   logic [1:0]             count_reg;
   logic                   push_ok;
   logic                   pop_ok;

   assign pop_ok  = pop && (count_reg != 2'd0);
   assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         logic [CODE_WIDTH-1:0]  code_reg;
         logic [INDEX_WIDTH-1:0] index_reg;

         // Storage is left unreset; the empty-gated head keeps stale data invisible.
         always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg == 1'(gi))) begin
               code_reg  <= push_code;
               index_reg <= push_index;
            end
         end

         assign entry_code[gi]  = code_reg;
         assign entry_index[gi] = index_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   assign count      = count_reg;
   assign head_code  = (count_reg != 2'd0) ? entry_code[rd_ptr_reg]  : '0;
   assign head_index = (count_reg != 2'd0) ? entry_index[rd_ptr_reg] : '0;

endmodule

// File: rtl/code_fetch_sequencer.sv
// Program-counter sequencer: streams code words from storage to the decode register.
// Optional feature macro CODE_FETCH_HALT_OP_EN: a captured HALT_OP word ends the fetch.
module code_fetch_sequencer
   import neural_burning_pkg::*;
#(
   parameter int CODE_WIDTH  = DEFAULT_CODE_WIDTH,
   parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset,
   input  logic                   code_control_interface_active,
   input  logic                   code_control_interface_reset,
   input  logic [INDEX_WIDTH-1:0] code_length,
   output logic                   rd_en,
   output logic [INDEX_WIDTH-1:0] rd_addr,
   input  logic [CODE_WIDTH-1:0]  rd_data,
   output logic                   fetch_valid,
   input  logic                   fetch_ready,
   output logic [CODE_WIDTH-1:0]  fetch_code,
   output logic [INDEX_WIDTH-1:0] fetch_code_index,
   output logic                   busy,
   output logic                   done
);

   fetch_state_t           state_reg;
   logic [INDEX_WIDTH-1:0] pc_reg;
   logic [INDEX_WIDTH-1:0] len_reg;
   logic                   inflight_reg;
   logic [INDEX_WIDTH-1:0] inflight_idx_reg;
   logic [1:0]             buf_count;
   logic                   pop;
   logic                   push_word;
   logic                   issue;
   logic                   halt_stop;
   logic                   buf_drains;
   logic                   fetch_end;
   logic                   ctl_reset;

   assign ctl_reset = code_control_interface_reset;
   assign pop       = fetch_valid && fetch_ready;

`ifdef CODE_FETCH_HALT_OP_EN
   logic halted_reg;

   always_ff @(posedge clk_clk) begin
      if (reset_reset || ctl_reset || (state_reg == ST_IDLE)) begin
         halted_reg <= 1'b0;
      end else if (push_word && (rd_data[CODE_WIDTH-1 -: 4] == HALT_OP)) begin
         halted_reg <= 1'b1;
      end
   end

   assign halt_stop = halted_reg;
`else
   assign halt_stop = 1'b0;
`endif

   // A read issued behind a halt word is dropped rather than buffered.
   assign push_word = inflight_reg && !halt_stop;

   // Slot reservation: buffered + in-flight words after this cycle's pop must leave room.
   assign issue = (state_reg == ST_FETCH) && code_control_interface_active &&
                  (pc_reg < len_reg) && !halt_stop &&
                  (({1'b0, buf_count} + {2'b00, inflight_reg}) <= (3'd1 + {2'b00, pop}));

   assign buf_drains = (buf_count == 2'd0) || ((buf_count == 2'd1) && pop);
   assign fetch_end  = ((pc_reg == len_reg) || halt_stop) && !push_word && buf_drains;

   always_ff @(posedge clk_clk) begin
      if (reset_reset || ctl_reset) begin
         state_reg        <= ST_IDLE;
         pc_reg           <= '0;
         len_reg          <= '0;
         inflight_reg     <= 1'b0;
         inflight_idx_reg <= '0;
      end else begin
         inflight_reg <= issue;
         if (issue) inflight_idx_reg <= pc_reg;
         case (state_reg)
            ST_IDLE: begin
               if (code_control_interface_active) begin
                  if (code_length != '0) begin
                     state_reg <= ST_FETCH;
                     len_reg   <= code_length;
                     pc_reg    <= '0;
                  end else begin
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_FETCH: begin
               if (issue)     pc_reg    <= pc_reg + 1'b1;
               if (fetch_end) state_reg <= ST_DONE;
            end
            ST_DONE:  state_reg <= ST_DONE;
            default:  state_reg <= ST_IDLE;
         endcase
      end
   end

   fetch_skid_buffer #(
      .CODE_WIDTH (CODE_WIDTH),
      .INDEX_WIDTH(INDEX_WIDTH)
   ) u_skid (
      .clk       (clk_clk),
      .srst      (reset_reset),
      .flush     (ctl_reset),
      .push      (push_word),
      .push_code (rd_data),
      .push_index(inflight_idx_reg),
      .pop       (pop),
      .head_code (fetch_code),
      .head_index(fetch_code_index),
      .count     (buf_count)
   );

   assign rd_en       = issue;
   assign rd_addr     = pc_reg;
   assign fetch_valid = (buf_count != 2'd0);
   assign busy        = (state_reg == ST_FETCH);
   assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_code_fetch_sequencer.sv
// Directed bench for code_fetch_sequencer with a behavioural one-cycle-latency storage.
// Halt expectations follow CODE_FETCH_HALT_OP_EN when the bench is built with it.
module tb_code_fetch_sequencer;
   localparam int CW = 12;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          reset_reset;
   logic          active;
   logic          ctl_reset;
   logic [IW-1:0] code_length;
   logic          rd_en;
   logic [IW-1:0] rd_addr;
   logic [CW-1:0] rd_data;
   logic          fetch_valid;
   logic          fetch_ready;
   logic [CW-1:0] fetch_code;
   logic [IW-1:0] fetch_code_index;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   code_fetch_sequencer #(.CODE_WIDTH(CW), .INDEX_WIDTH(IW)) dut (
      .clk_clk                      (clk),
      .reset_reset                  (reset_reset),
      .code_control_interface_active(active),
      .code_control_interface_reset (ctl_reset),
      .code_length                  (code_length),
      .rd_en                        (rd_en),
      .rd_addr                      (rd_addr),
      .rd_data                      (rd_data),
      .fetch_valid                  (fetch_valid),
      .fetch_ready                  (fetch_ready),
      .fetch_code                   (fetch_code),
      .fetch_code_index             (fetch_code_index),
      .busy                         (busy),
      .done                         (done)
   );

   logic [CW-1:0] mem [16];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];

   int            total = 0;
   int            bad   = 0;
   int            issued;
   int            accepted;
   logic [CW-1:0] got_code [$];
   logic [IW-1:0] got_idx  [$];
   logic          stall_prev;
   logic [CW-1:0] stall_code;
   logic [IW-1:0] stall_idx;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Sample one cycle at the falling edge, then advance to just after the next rising edge.
   task automatic step();
      @(negedge clk);
      if (stall_prev) begin
         check("stall_valid", fetch_valid, 1);
         check("stall_code", fetch_code, stall_code);
         check("stall_idx", fetch_code_index, stall_idx);
      end
      if (rd_en) issued++;
      if (fetch_valid && fetch_ready) begin
         got_code.push_back(fetch_code);
         got_idx.push_back(fetch_code_index);
         accepted++;
         $display("txn t=%0t idx=%0d code=0x%03h", $time, fetch_code_index, fetch_code);
      end
      check("outstanding_le3", 64'((issued - accepted) <= 3), 1);
      stall_prev = fetch_valid && !fetch_ready && !reset_reset && !ctl_reset;
      stall_code = fetch_code;
      stall_idx  = fetch_code_index;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      got_code.delete();
      got_idx.delete();
      issued   = 0;
      accepted = 0;
   endtask

   task automatic do_reset();
      reset_reset = 1'b1;
      active      = 1'b0;
      ctl_reset   = 1'b0;
      fetch_ready = 1'b0;
      repeat (2) step();
      reset_reset = 1'b0;
      stall_prev  = 1'b0;
      clear_log();
   endtask

   task automatic run_until_done(input string tag, input int bound);
      for (int k = 0; k < bound && !done; k++) step();
      check(tag, done, 1);
   endtask

   task automatic check_seq(input string tag, input logic [CW-1:0] base, input int n, input int halt_at);
      check({tag, "_count"}, got_code.size(), n);
      for (int i = 0; i < n && i < got_code.size(); i++) begin
         check({tag, "_idx"}, got_idx[i], i);
         check({tag, "_code"}, got_code[i], (i == halt_at) ? CW'(12'hF00) : CW'(base + CW'(i)));
      end
   endtask

   task automatic load_mem(input logic [CW-1:0] base);
      for (int i = 0; i < 16; i++) mem[i] = base + CW'(i);
   endtask

   initial begin
      reset_reset = 1'b1;
      active      = 1'b0;
      ctl_reset   = 1'b0;
      fetch_ready = 1'b0;
      code_length = '0;
      stall_prev  = 1'b0;
      issued      = 0;
      accepted    = 0;
      load_mem(12'h101);
      @(posedge clk);
      #1;

      // Reset values
      do_reset();
      #1;
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_valid", fetch_valid, 0);
      check("rst_code", fetch_code, 0);
      check("rst_idx", fetch_code_index, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // Length 4, ready held high: valid cycles 3..6, done in cycle 7
      code_length = 4;
      fetch_ready = 1'b1;
      active      = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         #1;
         check("t1_rd_en", rd_en, (k >= 1 && k <= 4));
         if (rd_en) check("t1_rd_addr", rd_addr, k - 1);
         check("t1_valid", fetch_valid, (k >= 3 && k <= 6));
         if (k >= 3 && k <= 6) begin
            check("t1_idx", fetch_code_index, k - 3);
            check("t1_code", fetch_code, 12'h101 + k - 3);
         end
         check("t1_busy", busy, (k >= 1 && k <= 6));
         check("t1_done", done, (k >= 7));
         step();
      end
      check_seq("t1", 12'h101, 4, -1);

      // Ready low: two issues fill the buffer, then nothing more is issued
      load_mem(12'h201);
      do_reset();
      code_length = 6;
      active      = 1'b1;
      repeat (9) step();
      check("t2_full_issues", issued, 2);
      check("t2_full_valid", fetch_valid, 1);
      check("t2_full_code", fetch_code, 12'h201);
      // Ready pattern 1,0,0 repeating
      for (int k = 0; k < 80 && !done; k++) begin
         fetch_ready = ((k % 3) == 0);
         step();
      end
      check("t2_done", done, 1);
      check_seq("t2", 12'h201, 6, -1);

      // Active dropped after two issues, restored five cycles later
      load_mem(12'h301);
      do_reset();
      code_length = 6;
      fetch_ready = 1'b1;
      active      = 1'b1;
      repeat (3) step();
      active = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t3_paused_rd_en", rd_en, 0);
         check("t3_paused_busy", busy, 1);
         step();
      end
      check("t3_paused_issues", issued, 2);
      active = 1'b1;
      run_until_done("t3_done", 40);
      check_seq("t3", 12'h301, 6, -1);

      // Control reset coinciding with a handshake mid-program
      load_mem(12'h401);
      do_reset();
      code_length = 6;
      fetch_ready = 1'b1;
      active      = 1'b1;
      repeat (4) step();
      #1;
      check("t4_hs_valid", fetch_valid, 1);
      ctl_reset = 1'b1;
      step();
      ctl_reset = 1'b0;
      #1;
      check("t4_valid", fetch_valid, 0);
      check("t4_busy", busy, 0);
      check("t4_done", done, 0);
      check("t4_rd_en", rd_en, 0);
      check("t4_code", fetch_code, 0);
      check("t4_idx", fetch_code_index, 0);
      clear_log();
      run_until_done("t4_restart_done", 40);
      check_seq("t4", 12'h401, 6, -1);

      // Length 0: DONE after one cycle, no reads
      do_reset();
      code_length = 0;
      active      = 1'b1;
      step();
      #1;
      check("t5_done", done, 1);
      check("t5_busy", busy, 0);
      repeat (3) step();
      check("t5_done_hold", done, 1);
      check("t5_no_reads", issued, 0);
      ctl_reset = 1'b1;
      step();
      ctl_reset = 1'b0;
      #1;
      check("t5_ctl_reset_done", done, 0);

      // Halt word at line 3
      load_mem(12'h601);
      mem[3] = 12'hF00;
      do_reset();
      code_length = 8;
      fetch_ready = 1'b1;
      active      = 1'b1;
      run_until_done("t6_done", 40);
`ifdef CODE_FETCH_HALT_OP_EN
      check_seq("t6", 12'h601, 4, 3);
`else
      check_seq("t6", 12'h601, 8, 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
